// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch stage.
// Fetch FSM encodings, next-PC select codes and PC step.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DROP  = 2'b10
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect decode: decides whether a redirect is taken
// and which destination it selects.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic        i_valid,
  input  logic [2:0]  i_ctrl,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  output logic        o_taken,
  output logic [31:0] o_target
);

  logic [1:0] w_sel;
  logic       w_jump;
  logic       w_branch;

  assign w_sel    = i_ctrl[2:1];
  assign w_jump   = (w_sel == SEL_JUMP);
  assign w_branch = (w_sel == SEL_BRANCH) && i_ctrl[0];

  assign o_taken  = i_valid && (w_jump || w_branch);
  assign o_target = w_jump ? i_jump_target : i_branch_target;

endmodule

// File: rtl/pc_fetch.sv
// PC generation and instruction fetch with a one-entry
// output buffer toward decode.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [2:0]  ctrl,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target
);

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_pend, w_pend_nx;
  logic [31:0] r_instr, w_instr_nx;
  logic [31:0] r_ipc, w_ipc_nx;
  logic        r_valid, w_valid_nx;

  logic        w_taken;
  logic [31:0] w_target;

  pc_next_sel u_sel (
    .i_valid         (redirect_valid),
    .i_ctrl          (ctrl),
    .i_branch_target (branch_target),
    .i_jump_target   (jump_target),
    .o_taken         (w_taken),
    .o_target        (w_target)
  );

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_pend_nx  = r_pend;
    w_instr_nx = r_instr;
    w_ipc_nx   = r_ipc;
    w_valid_nx = r_valid;
    unique case (r_state)
      ST_FETCH: begin
        if (imem_ack && !w_taken) begin
          w_instr_nx = imem_rdata;
          w_ipc_nx   = r_pc;
          w_valid_nx = 1'b1;
          w_state_nx = ST_HOLD;
        end else if (imem_ack) begin
          w_pc_nx = w_target;
        end else if (w_taken) begin
          w_pend_nx  = w_target;
          w_state_nx = ST_DROP;
        end
      end
      ST_HOLD: begin
        // Redirect wins over consumption of the held word.
        if (w_taken) begin
          w_valid_nx = 1'b0;
          w_pc_nx    = w_target;
          w_state_nx = ST_FETCH;
        end else if (decode_ready) begin
          w_valid_nx = 1'b0;
          w_pc_nx    = r_pc + PC_STEP;
          w_state_nx = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (w_taken) begin
          w_pend_nx = w_target;
        end
        if (imem_ack) begin
          w_pc_nx    = w_taken ? w_target : r_pend;
          w_state_nx = ST_FETCH;
        end
      end
      default: begin
        w_valid_nx = 1'b0;
        w_state_nx = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_pend  <= RESET_PC;
      r_instr <= '0;
      r_ipc   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_pend  <= w_pend_nx;
      r_instr <= w_instr_nx;
      r_ipc   <= w_ipc_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign imem_req    = !reset && (r_state != ST_HOLD);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then random
// traffic, all checked against a behavioural model.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        redirect_valid;
  logic [2:0]  ctrl;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  int checks   = 0;
  int failures = 0;

  // model: fetch address, pending target, held word
  logic [31:0] m_pc, m_pend, m_instr, m_ipc;
  bit          m_has, m_drop;

  always #5 clock = ~clock;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .ctrl           (ctrl),
    .branch_target  (branch_target),
    .jump_target    (jump_target)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_upd();
    bit          tk;
    logic [31:0] tgt;
    tk  = redirect_valid &&
          (ctrl[2:1] == 2'b10 ||
           (ctrl[2:1] == 2'b01 && ctrl[0]));
    tgt = (ctrl[2:1] == 2'b10) ? jump_target
                               : branch_target;
    if (reset) begin
      m_pc = RST_PC; m_pend = RST_PC;
      m_has = 0; m_drop = 0;
      m_instr = 0; m_ipc = 0;
    end else if (m_has) begin
      if (tk) begin
        m_has = 0; m_pc = tgt;
      end else if (decode_ready) begin
        m_has = 0; m_pc = m_pc + 32'd4;
      end
    end else if (m_drop) begin
      if (tk) m_pend = tgt;
      if (imem_ack) begin
        m_pc = m_pend; m_drop = 0;
      end
    end else if (imem_ack) begin
      if (tk) m_pc = tgt;
      else begin
        m_has = 1; m_instr = imem_rdata; m_ipc = m_pc;
      end
    end else if (tk) begin
      m_pend = tgt; m_drop = 1;
    end
  endtask

  task automatic cmp();
    logic exp_req;
    exp_req = !reset && !m_has;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'd0, instr_valid},
        {31'd0, m_has});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
  endtask

  task automatic cyc();
    imem_rdata = $urandom;
    @(posedge clock);
    model_upd();
    #1;
    cmp();
  endtask

  task automatic idle();
    redirect_valid = 0; ctrl = 3'b000;
    imem_ack = 0; decode_ready = 0;
  endtask

  logic [31:0] saved;

  initial begin
    reset = 1; idle();
    branch_target = 0; jump_target = 0;
    imem_rdata = 0;
    m_pc = 0; m_pend = 0; m_instr = 0; m_ipc = 0;
    m_has = 0; m_drop = 0;
    repeat (3) cyc();
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // back-to-back fetch at full rate
    reset = 0; imem_ack = 1; decode_ready = 1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k % 2 == 0) begin
        chk("seq_valid", {31'd0, instr_valid}, 32'd1);
        chk("seq_pc", instr_pc, 32'(k * 2));
      end else begin
        chk("seq_gap", {31'd0, instr_valid}, 32'd0);
      end
    end

    // hold with decode stalled
    decode_ready = 0;
    for (int k = 0; k < 4 && !m_has; k++) cyc();
    chk("hold_reach", {31'd0, instr_valid}, 32'd1);
    saved = m_ipc;
    imem_ack = 0;
    repeat (5) cyc();
    decode_ready = 1;
    cyc();
    chk("hold_next", imem_addr, saved + 32'd4);

    // jump while a fetch is outstanding
    decode_ready = 0;
    redirect_valid = 1; ctrl = 3'b100;
    jump_target = 32'h100;
    cyc();
    idle();
    repeat (2) cyc();
    imem_ack = 1;
    cyc();
    chk("drop_valid", {31'd0, instr_valid}, 32'd0);
    chk("drop_addr", imem_addr, 32'h100);

    // branch not taken, then taken, in hold
    cyc();
    chk("br_hold", {31'd0, instr_valid}, 32'd1);
    idle();
    redirect_valid = 1; ctrl = 3'b010;
    branch_target = 32'h40;
    cyc();
    chk("br_nt", {31'd0, instr_valid}, 32'd1);
    ctrl = 3'b011;
    cyc();
    chk("br_t_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_t_addr", imem_addr, 32'h40);

    // wrap at top of address space
    ctrl = 3'b100; jump_target = 32'hFFFF_FFFC;
    cyc();
    idle(); imem_ack = 1;
    cyc();
    cyc();
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    imem_ack = 0; decode_ready = 1;
    cyc();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // reset during drop loses the pending target
    idle();
    redirect_valid = 1; ctrl = 3'b100;
    jump_target = 32'h200;
    cyc();
    idle(); reset = 1; imem_ack = 1;
    cyc();
    reset = 0; imem_ack = 0;
    cyc();
    chk("rst_drop_req", {31'd0, imem_req}, 32'd1);
    chk("rst_drop_addr", imem_addr, RST_PC);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(99) == 0);
      imem_ack       = $urandom_range(1);
      decode_ready   = $urandom_range(1);
      redirect_valid = ($urandom_range(9) < 4);
      ctrl           = 3'($urandom);
      branch_target  = $urandom & 32'hFFFF_FFFC;
      jump_target    = $urandom & 32'hFFFF_FFFC;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address of the first fetch after reset.
REQ-002 clock  input  1  single clock for all state; every register updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  read address; held stable while imem_req is high.
REQ-006 imem_ack  input  1  memory completes the current request this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack is high.
REQ-008 instr  output  32  fetched instruction presented to decode.
REQ-009 instr_pc  output  32  address of instr.
REQ-010 instr_valid  output  1  instr and instr_pc are valid.
REQ-011 decode_ready  input  1  decode consumes instr this cycle when instr_valid is high.
REQ-012 redirect_valid  input  1  ctrl, branch_target and jump_target are meaningful this cycle.
REQ-013 ctrl  input  3  next-PC select: [2:1] 00 sequential, 01 branch, 10 jump, 11 sequential; [0] branch condition.
REQ-014 branch_target  input  32  taken-branch destination.
REQ-015 jump_target  input  32  jump destination.

Function
REQ-016 A redirect is "taken" when redirect_valid=1 and either ctrl[2:1]=10 (target jump_target) or ctrl[2:1]=01 with ctrl[0]=1 (target branch_target); all other cases are not taken and do nothing.
REQ-017 FSM states: FETCH, HOLD and DROP.
REQ-018 FETCH: imem_req=1 and imem_addr=pc.
  - ack without a taken redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - ack with a taken redirect: discard the data, pc<=target, stay in FETCH.
  - taken redirect without ack: pending<=target, go to DROP.
REQ-019 HOLD: imem_req=0.
  - taken redirect: instr_valid<=0, pc<=target, go to FETCH. A redirect has priority over decode_ready.
  - otherwise decode_ready=1: instr_valid<=0, pc<=pc+4, go to FETCH.
  - otherwise: hold all outputs.
REQ-020 DROP: imem_req=1 with the unchanged old address.
  - A further taken redirect overwrites pending.
  - On ack: discard the data, pc<=pending (or the same-cycle redirect target), go to FETCH.
REQ-021 pc+4 wraps modulo 2^32; 32'hFFFFFFFC advances to 32'h00000000.
REQ-022 instr_valid is never high in FETCH or DROP; a discarded word never reaches instr.
REQ-023 Minimum latency: ack in the first FETCH cycle gives instr_valid=1 in the next cycle.
REQ-024 Sustained throughput with ack=1 and decode_ready=1: one instruction every 2 cycles.

Reset
REQ-025 While reset=1, on every rising clock edge:
  - state<=FETCH, pc<=RESET_PC, pending<=RESET_PC.
  - instr<=0, instr_pc<=0, instr_valid<=0.
REQ-026 During reset, imem_req=0.
REQ-027 Reset asserted mid-access (FETCH or DROP) abandons the access; an ack arriving during reset is ignored.
REQ-028 The first request after reset is issued in the first cycle with reset=0, at RESET_PC.

Structure
REQ-029 A shared package holds:
  - the FSM state encodings.
  - the select codes SEL_SEQ=2'b00, SEL_BRANCH=2'b01, SEL_JUMP=2'b10.
  - the constant PC_STEP=32'd4.
REQ-030 Taken detection and target selection live in one combinational sub-module, pc_next_sel, shared by the FETCH, HOLD and DROP paths.

Verification
REQ-031 Reset, then ack=1 and decode_ready=1 constantly -> instr_pc sequence 0,4,8,12; instr_valid high every other cycle.
REQ-032 HOLD with decode_ready=0 for 5 cycles -> instr and instr_pc stable, imem_req=0; then decode_ready=1 -> next fetch at instr_pc+4.
REQ-033 In FETCH with ack low, ctrl=3'b100, jump_target=32'h100, then ack 3 cycles later -> the old word is discarded and the next imem_addr is 32'h100.
REQ-034 In HOLD, ctrl=3'b010 (branch not taken) with branch_target=32'h40 -> ignored; ctrl=3'b011 -> instr_valid drops and imem_addr is 32'h40.
REQ-035 pc=32'hFFFFFFFC consumed -> next imem_addr is 32'h00000000.
REQ-036 reset asserted in DROP -> next imem_addr is RESET_PC, and the pending target is lost.
